// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_pkg
// Description : Shared types and helpers for the MEM pipeline stage:
//               payload structs, FSM state encoding, access size and
//               byte-strobe helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_stage_pkg;

  localparam int XLEN      = 64;
  localparam int BUS_BYTES = 8;

  typedef logic [XLEN-1:0]      word_t;
  typedef logic [BUS_BYTES-1:0] strobe_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DONE  = 2'd2,
    DRAIN = 2'd3
  } mem_state_t;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  // Source of the next out_data value
  typedef enum logic [1:0] {
    OUT_HOLD   = 2'd0,
    OUT_BUBBLE = 2'd1,
    OUT_RESULT = 2'd2,
    OUT_BUF    = 2'd3
  } out_sel_t;

  // Load funct3 encodings (stores reuse the low two bits as size)
  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LD  = 3'd3;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_LWU = 3'd6;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic exception;
    logic load_address_misaligned;
    logic store_address_misaligned;
  } ctl_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    ctl_t        ctl;
    logic [4:0]  dst;
    word_t       aluout;
    word_t       rd;
    logic [11:0] csr_addr;
    word_t       csr_wdata;
  } exec_data_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    ctl_t        ctl;
    logic [4:0]  dst;
    word_t       writedata;
    word_t       mem_addr;
    logic [11:0] csr_addr;
    word_t       csr_wdata;
  } mem_data_t;

  typedef struct packed {
    logic [4:0] dst;
    word_t      data;
    logic       valid;
  } fwd_data_t;

  // Access size comes straight from funct3[1:0]
  function automatic msize_t size_of(input logic [2:0] funct3);
    return msize_t'({1'b0, funct3[1:0]});
  endfunction

  // Byte enables for a store of the given size at the given byte lane
  function automatic strobe_t strobe_of(input msize_t size, input logic [2:0] off);
    strobe_t s;
    case (size)
      MSIZE1:  s = strobe_t'(8'h01) << off;
      MSIZE2:  s = strobe_t'(8'h03) << off;
      MSIZE4:  s = strobe_t'(8'h0F) << off;
      MSIZE8:  s = '1;
      default: s = '0;
    endcase
    return s;
  endfunction

  // True when the byte offset is a multiple of the access size
  function automatic logic is_aligned(input msize_t size, input logic [2:0] off);
    logic ok;
    case (size)
      MSIZE1:  ok = 1'b1;
      MSIZE2:  ok = ~off[0];
      MSIZE4:  ok = (off[1:0] == 2'b00);
      MSIZE8:  ok = (off == 3'b000);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_stage_align.sv
`default_nettype none
// ============================================================================
// Module      : mem_align
// Description : Combinational byte-lane logic: store strobes, store data
//               lane shift and load sign/zero extension.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_align
  import mem_stage_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic [2:0] offset,
  input  logic       is_store,
  input  word_t      store_src,
  input  word_t      load_raw,
  output strobe_t    strobe,
  output word_t      store_data,
  output word_t      load_data
);

  word_t      shifted;
  logic [5:0] bit_shift;

  assign bit_shift = {offset, 3'b000};

  // Lane placement for stores, lane extraction and extension for loads
  always_comb begin
    strobe     = is_store ? strobe_of(size_of(funct3), offset) : '0;
    store_data = store_src << bit_shift;
    shifted    = load_raw >> bit_shift;
    case (funct3)
      F3_LB:   load_data = {{56{shifted[7]}},  shifted[7:0]};
      F3_LH:   load_data = {{48{shifted[15]}}, shifted[15:0]};
      F3_LW:   load_data = {{32{shifted[31]}}, shifted[31:0]};
      F3_LBU:  load_data = {56'd0, shifted[7:0]};
      F3_LHU:  load_data = {48'd0, shifted[15:0]};
      F3_LWU:  load_data = {32'd0, shifted[31:0]};
      default: load_data = shifted;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage
// Description : Pipeline MEM stage. Issues load/store requests on the data
//               bus, stalls upstream during multi-cycle accesses, extends
//               load data and registers the MEM->WB payload.
//               Optional feature macro: MEM_MISALIGN_TRAP_EN (misaligned
//               accesses trap without a bus request).
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  exec_data_t in_data,
  input  logic       stall_i,
  input  logic       flush,
  output logic       stall_o,
  output mem_data_t  out_data,
  output fwd_data_t  fwd,
  output logic       dreq_valid,
  output word_t      dreq_addr,
  output logic [2:0] dreq_size,
  output strobe_t    dreq_strobe,
  output word_t      dreq_data,
  input  logic       dresp_addr_ok,
  input  logic       dresp_data_ok,
  input  word_t      dresp_data
);

  mem_state_t state, state_next;
  exec_data_t req;        // request captured at issue, drives the bus after IDLE
  exec_data_t cur;        // instruction currently owned by the stage
  mem_data_t  hold_buf;   // completed result waiting for stall_i to drop
  mem_data_t  result;
  out_sel_t   out_sel;
  logic       capture_req, load_buf;
  logic       mem_op, misalign, misalign_now;
  out_sel_t   idle_sel;
  strobe_t    al_strobe;
  word_t      al_store, al_load;

  // Address acceptance is informational only; the stage waits on data_ok
  logic unused_addr_ok;
  assign unused_addr_ok = dresp_addr_ok;

  assign mem_op = in_data.valid & (in_data.ctl.mem_read | in_data.ctl.mem_write)
                & ~in_data.ctl.exception;

`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign = mem_op & ~is_aligned(size_of(in_data.instr[14:12]), in_data.aluout[2:0]);
`else
  assign misalign = 1'b0;
`endif

  assign misalign_now = (state == IDLE) & misalign;
  assign cur          = (state == IDLE) ? in_data : req;
  assign idle_sel     = stall_i ? OUT_HOLD : OUT_BUBBLE;

  mem_align u_align (
    .funct3     (cur.instr[14:12]),
    .offset     (cur.aluout[2:0]),
    .is_store   (cur.ctl.mem_write),
    .store_src  (cur.rd),
    .load_raw   (dresp_data),
    .strobe     (al_strobe),
    .store_data (al_store),
    .load_data  (al_load)
  );

  // Build the MEM->WB payload for the current instruction
  always_comb begin
    result           = '0;
    result.valid     = 1'b1;
    result.instr     = cur.instr;
    result.ctl       = cur.ctl;
    result.dst       = cur.dst;
    result.mem_addr  = cur.aluout;
    result.csr_addr  = cur.csr_addr;
    result.csr_wdata = cur.csr_wdata;
    result.writedata = (cur.ctl.mem_read & ~cur.ctl.exception & ~misalign_now)
                     ? al_load : cur.aluout;
    if (misalign_now) begin
      result.ctl.load_address_misaligned  = cur.ctl.mem_read;
      result.ctl.store_address_misaligned = cur.ctl.mem_write;
      result.ctl.exception                = 1'b1;
    end
  end

  // Next-state, handshake and output-select decode. stall_o drops on the
  // cycle the instruction retires or is discarded so upstream advances on
  // the same edge instead of re-presenting it.
  always_comb begin
    state_next  = state;
    dreq_valid  = 1'b0;
    stall_o     = 1'b0;
    out_sel     = OUT_HOLD;
    capture_req = 1'b0;
    load_buf    = 1'b0;
    case (state)
      IDLE: begin
        if (flush) begin
          out_sel = OUT_BUBBLE;
        end else if (mem_op && !misalign) begin
          dreq_valid  = 1'b1;
          capture_req = 1'b1;
          if (dresp_data_ok && !stall_i) begin
            out_sel = OUT_RESULT;
          end else if (dresp_data_ok) begin
            load_buf   = 1'b1;
            state_next = DONE;
            stall_o    = 1'b1;
          end else begin
            state_next = BUSY;
            stall_o    = 1'b1;
            out_sel    = idle_sel;
          end
        end else if (in_data.valid) begin
          if (stall_i) stall_o = 1'b1;
          else         out_sel = OUT_RESULT;
        end else begin
          out_sel = idle_sel;
        end
      end
      BUSY: begin
        dreq_valid = 1'b1;
        stall_o    = 1'b1;
        if (flush) begin
          // The bus cannot abort: drain unless it finishes right now
          out_sel    = OUT_BUBBLE;
          state_next = dresp_data_ok ? IDLE : DRAIN;
          stall_o    = ~dresp_data_ok;
        end else if (dresp_data_ok && !stall_i) begin
          out_sel    = OUT_RESULT;
          state_next = IDLE;
          stall_o    = 1'b0;
        end else if (dresp_data_ok) begin
          load_buf   = 1'b1;
          state_next = DONE;
        end else begin
          out_sel = idle_sel;
        end
      end
      DONE: begin
        stall_o = 1'b1;
        if (flush) begin
          out_sel    = OUT_BUBBLE;
          state_next = IDLE;
          stall_o    = 1'b0;
        end else if (!stall_i) begin
          out_sel    = OUT_BUF;
          state_next = IDLE;
          stall_o    = 1'b0;
        end
      end
      DRAIN: begin
        dreq_valid = 1'b1;
        stall_o    = 1'b1;
        out_sel    = (flush || !stall_i) ? OUT_BUBBLE : OUT_HOLD;
        if (dresp_data_ok) begin
          state_next = IDLE;
          stall_o    = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Bus request fields are forced to zero whenever no request is active
  always_comb begin
    dreq_addr   = dreq_valid ? cur.aluout : '0;
    dreq_size   = dreq_valid ? size_of(cur.instr[14:12]) : 3'd0;
    dreq_strobe = dreq_valid ? al_strobe : '0;
    dreq_data   = dreq_valid ? al_store : '0;
  end

  // State register; reset abandons any transaction in flight
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Request capture, hold buffer and MEM->WB payload register
  always_ff @(posedge clk) begin
    if (reset) begin
      req      <= '0;
      hold_buf <= '0;
      out_data <= '0;
    end else begin
      if (capture_req) req      <= in_data;
      if (load_buf)    hold_buf <= result;
      case (out_sel)
        OUT_BUBBLE: out_data <= '0;
        OUT_RESULT: out_data <= result;
        OUT_BUF:    out_data <= hold_buf;
        default:    out_data <= out_data;
      endcase
    end
  end

  assign fwd = '{dst: out_data.dst, data: out_data.writedata,
                 valid: out_data.valid & out_data.ctl.reg_write};

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage
// Description : Self-checking bench for mem_stage: single-cycle vector table
//               plus directed multi-cycle sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic       clk = 1'b0;
  logic       reset, stall_i, flush, stall_o;
  exec_data_t in_data;
  mem_data_t  out_data;
  fwd_data_t  fwd;
  logic       dreq_valid, dresp_addr_ok, dresp_data_ok;
  word_t      dreq_addr, dreq_data, dresp_data;
  logic [2:0] dreq_size;
  strobe_t    dreq_strobe;

  int checks = 0;
  int fails  = 0;

  localparam word_t BASE = 64'h0000_0000_8000_1000;

  mem_stage dut (
    .clk(clk), .reset(reset), .in_data(in_data), .stall_i(stall_i), .flush(flush),
    .stall_o(stall_o), .out_data(out_data), .fwd(fwd),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data)
  );

  always #5 clk = ~clk;
  assign dresp_addr_ok = dreq_valid;

  typedef struct {
    string      name;
    logic [2:0] f3;
    logic       rdm, wrm, rw, exc;
    word_t      addr, rd, resp;
    logic       exp_req;
    strobe_t    exp_strobe;
    word_t      exp_bus, exp_wdata;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mkv(input string n, input logic [2:0] f3,
                               input logic rdm, wrm, rw, exc,
                               input word_t addr, rd, resp, input logic req,
                               input strobe_t stb, input word_t bus, wd);
    vec_t v;
    v.name = n; v.f3 = f3; v.rdm = rdm; v.wrm = wrm; v.rw = rw; v.exc = exc;
    v.addr = addr; v.rd = rd; v.resp = resp; v.exp_req = req;
    v.exp_strobe = stb; v.exp_bus = bus; v.exp_wdata = wd;
    return v;
  endfunction

  function automatic exec_data_t mki(input logic [2:0] f3, input logic rdm, wrm, rw, exc,
                                     input word_t addr, rd);
    exec_data_t e;
    e = '0;
    e.valid = 1'b1;
    e.instr = {17'h0, f3, 12'h003};
    e.ctl.reg_write = rw; e.ctl.mem_read = rdm; e.ctl.mem_write = wrm; e.ctl.exception = exc;
    e.dst = 5'd7; e.aluout = addr; e.rd = rd; e.csr_addr = 12'h300;
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    word_t addr_seen;
    int    stalls;

    reset = 1'b1; in_data = '0; stall_i = 1'b0; flush = 1'b0;
    dresp_data_ok = 1'b0; dresp_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_data.valid, 0);
    check("rst_stall_o",   stall_o, 0);
    check("rst_dreq_valid", dreq_valid, 0);
    check("rst_dreq_addr", dreq_addr, 0);
    check("rst_fwd_valid", fwd.valid, 0);
    reset = 1'b0;

    //          name    f3 rd wr rw ex addr      rd                      resp                    req strobe bus                     writedata
    vecs[0]  = mkv("ADD", 3'd0,0,0,1,0, 64'h1234, 64'h0, 64'h0, 0, 8'h00, 64'h0, 64'h1234);
    vecs[1]  = mkv("LB",  3'd0,1,0,1,0, BASE+3, 64'h0, 64'h0000_0000_8000_0000, 1, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_FF80);
    vecs[2]  = mkv("LBU", 3'd4,1,0,1,0, BASE+3, 64'h0, 64'h0000_0000_8000_0000, 1, 8'h00, 64'h0, 64'h80);
    vecs[3]  = mkv("LH",  3'd1,1,0,1,0, BASE+2, 64'h0, 64'h0000_0000_8001_0000, 1, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_8001);
    vecs[4]  = mkv("LHU", 3'd5,1,0,1,0, BASE+6, 64'h0, 64'hBEEF_0000_0000_0000, 1, 8'h00, 64'h0, 64'hBEEF);
    vecs[5]  = mkv("LW",  3'd2,1,0,1,0, BASE+4, 64'h0, 64'h9000_0001_0000_0000, 1, 8'h00, 64'h0, 64'hFFFF_FFFF_9000_0001);
    vecs[6]  = mkv("LWU", 3'd6,1,0,1,0, BASE+4, 64'h0, 64'h9000_0001_0000_0000, 1, 8'h00, 64'h0, 64'h9000_0001);
    vecs[7]  = mkv("LD",  3'd3,1,0,1,0, BASE,   64'h0, 64'h0123_4567_89AB_CDEF, 1, 8'h00, 64'h0, 64'h0123_4567_89AB_CDEF);
    vecs[8]  = mkv("SB",  3'd0,0,1,0,0, BASE+5, 64'h55, 64'h0, 1, 8'h20, 64'h0000_5500_0000_0000, BASE+5);
    vecs[9]  = mkv("SH",  3'd1,0,1,0,0, BASE+6, 64'hABCD, 64'h0, 1, 8'hC0, 64'hABCD_0000_0000_0000, BASE+6);
    vecs[10] = mkv("SW",  3'd2,0,1,0,0, BASE+4, 64'hDEAD_BEEF, 64'h0, 1, 8'hF0, 64'hDEAD_BEEF_0000_0000, BASE+4);
    vecs[11] = mkv("SD",  3'd3,0,1,0,0, BASE,   64'h1122_3344_5566_7788, 64'h0, 1, 8'hFF, 64'h1122_3344_5566_7788, BASE);
    vecs[12] = mkv("EXC", 3'd3,1,0,1,1, BASE+8, 64'h0, 64'h0, 0, 8'h00, 64'h0, BASE+8);

    // Single-cycle completions: data_ok in the issue cycle
    foreach (vecs[i]) begin
      tick();
      in_data       = mki(vecs[i].f3, vecs[i].rdm, vecs[i].wrm, vecs[i].rw, vecs[i].exc,
                          vecs[i].addr, vecs[i].rd);
      dresp_data_ok = vecs[i].exp_req;
      dresp_data    = vecs[i].resp;
      mid();
      check({vecs[i].name, "_dreq_valid"}, dreq_valid, vecs[i].exp_req);
      check({vecs[i].name, "_dreq_addr"}, dreq_addr, vecs[i].exp_req ? vecs[i].addr : 64'h0);
      check({vecs[i].name, "_dreq_size"}, dreq_size,
            vecs[i].exp_req ? {1'b0, vecs[i].f3[1:0]} : 3'd0);
      check({vecs[i].name, "_strobe"}, dreq_strobe, vecs[i].exp_strobe);
      check({vecs[i].name, "_dreq_data"}, dreq_data, vecs[i].exp_bus);
      check({vecs[i].name, "_stall_o"}, stall_o, 0);
      tick();
      in_data.valid = 1'b0; dresp_data_ok = 1'b0;
      check({vecs[i].name, "_out_valid"}, out_data.valid, 1);
      check({vecs[i].name, "_writedata"}, out_data.writedata, vecs[i].exp_wdata);
      check({vecs[i].name, "_mem_addr"}, out_data.mem_addr, vecs[i].addr);
      check({vecs[i].name, "_fwd_valid"}, fwd.valid, vecs[i].rw);
      check({vecs[i].name, "_fwd_data"}, fwd.data, vecs[i].exp_wdata);
    end

    // Multi-cycle LB: data_ok after three stalled cycles, request stable
    tick();
    in_data = mki(3'd0, 1, 0, 1, 0, BASE+3, 64'h0);
    dresp_data = 64'h0000_0000_8000_0000;
    stalls = 0;
    mid();
    addr_seen = dreq_addr;
    check("mc_addr", addr_seen, BASE+3);
    for (int c = 0; c < 3; c++) begin
      if (c > 0) begin
        mid();
        check("mc_dreq_hold", dreq_valid, 1);
        check("mc_addr_hold", dreq_addr, addr_seen);
        check("mc_strobe_hold", dreq_strobe, 0);
        check("mc_bubble", out_data.valid, 0);
      end
      if (stall_o) stalls++;
      tick();
    end
    dresp_data_ok = 1'b1;
    mid();
    check("mc_stall_cycles", stalls, 3);
    check("mc_release", stall_o, 0);
    tick();
    in_data.valid = 1'b0; dresp_data_ok = 1'b0;
    check("mc_out_valid", out_data.valid, 1);
    check("mc_writedata", out_data.writedata, 64'hFFFF_FFFF_FFFF_FF80);

    // Downstream stall holds out_data and withholds an IDLE completion
    in_data = mki(3'd0, 0, 0, 1, 0, 64'h111, 64'h0);
    tick();
    in_data = mki(3'd0, 0, 0, 1, 0, 64'h222, 64'h0);
    stall_i = 1'b1;
    mid();
    check("hold_stall_o", stall_o, 1);
    tick();
    check("hold_out", out_data.writedata, 64'h111);
    stall_i = 1'b0;
    mid();
    check("hold_release", stall_o, 0);
    tick();
    check("hold_next", out_data.writedata, 64'h222);
    // Flush in IDLE beats stall_i
    in_data = mki(3'd0, 0, 0, 1, 0, 64'h333, 64'h0);
    flush = 1'b1; stall_i = 1'b1;
    tick();
    flush = 1'b0; stall_i = 1'b0; in_data.valid = 1'b0;
    check("flush_idle_valid", out_data.valid, 0);

    // LD completes under stall_i -> DONE, released when stall_i drops
    in_data = mki(3'd3, 1, 0, 1, 0, BASE+8, 64'h0);
    tick();
    dresp_data_ok = 1'b1; dresp_data = 64'hCAFE_F00D_1234_5678; stall_i = 1'b1;
    mid();
    check("done_stall_entry", stall_o, 1);
    tick();
    dresp_data_ok = 1'b0;
    mid();
    check("done_stall_o", stall_o, 1);
    check("done_no_req", dreq_valid, 0);
    tick();
    check("done_held", out_data.valid, 0);
    stall_i = 1'b0;
    mid();
    check("done_release", stall_o, 0);
    tick();
    in_data.valid = 1'b0;
    check("done_out_valid", out_data.valid, 1);
    check("done_writedata", out_data.writedata, 64'hCAFE_F00D_1234_5678);

    // Flush in BUSY -> DRAIN until data_ok, result discarded
    in_data = mki(3'd2, 1, 0, 1, 0, BASE+4, 64'h0);
    tick();
    flush = 1'b1;
    mid();
    check("drain_entry_stall", stall_o, 1);
    tick();
    flush = 1'b0;
    mid();
    check("drain_dreq_valid", dreq_valid, 1);
    check("drain_addr", dreq_addr, BASE+4);
    check("drain_stall", stall_o, 1);
    tick();
    dresp_data_ok = 1'b1; dresp_data = 64'h7777_7777_7777_7777;
    mid();
    check("drain_release", stall_o, 0);
    tick();
    in_data.valid = 1'b0; dresp_data_ok = 1'b0;
    check("drain_out_valid", out_data.valid, 0);
    check("drain_fwd_valid", fwd.valid, 0);
    mid();
    check("drain_idle_req", dreq_valid, 0);

    // Flush in DONE drops the hold buffer
    in_data = mki(3'd0, 0, 0, 1, 0, 64'h444, 64'h0);
    tick();
    in_data = mki(3'd3, 1, 0, 1, 0, BASE, 64'h0);
    dresp_data_ok = 1'b1; dresp_data = 64'h5555; stall_i = 1'b1;
    mid();
    check("dflush_stall", stall_o, 1);
    tick();
    dresp_data_ok = 1'b0; in_data.valid = 1'b0; flush = 1'b1;
    check("dflush_held", out_data.writedata, 64'h444);
    tick();
    flush = 1'b0; stall_i = 1'b0;
    check("dflush_valid", out_data.valid, 0);
    tick();
    check("dflush_dropped", out_data.valid, 0);

    // Reset mid-transaction returns straight to IDLE
    in_data = mki(3'd2, 1, 0, 1, 0, BASE+4, 64'h0);
    tick();
    reset = 1'b1; in_data.valid = 1'b0;
    tick();
    reset = 1'b0;
    mid();
    check("rst_mid_req", dreq_valid, 0);
    check("rst_mid_stall", stall_o, 0);

`ifdef MEM_MISALIGN_TRAP_EN
    // Misaligned LW traps without a bus request
    tick();
    in_data = mki(3'd2, 1, 0, 1, 0, BASE+2, 64'h0);
    mid();
    check("mis_no_req", dreq_valid, 0);
    check("mis_stall", stall_o, 0);
    tick();
    in_data.valid = 1'b0;
    check("mis_out_valid", out_data.valid, 1);
    check("mis_load_flag", out_data.ctl.load_address_misaligned, 1);
    check("mis_exception", out_data.ctl.exception, 1);
`endif

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
